// File: rtl/regfile_pkg.sv
// Shared types and address helpers for the two-read/one-write register file.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

    // True when the address names a real, writable/readable entry.
    function automatic logic addr_valid(input int unsigned addr, input int unsigned depth,
                                        input logic zero_reg0);
        return addr_in_range(addr, depth) && !(zero_reg0 && (addr == 0));
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: output register with bypass, zero-register and range selection.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDRESSWIDTH = 3,
    parameter int unsigned BYPASS       = 1,
    parameter int unsigned ZERO_REG0    = 0
) (
    input  logic                    clock_i,
    input  logic                    rst_ni,
    input  logic                    ready_i,
    input  logic                    rd_en_i,
    input  logic [ADDRESSWIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]        rf_data_i,
    input  logic                    wr_en_i,
    input  logic [ADDRESSWIDTH-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]        wr_data_i,
    output logic [WIDTH-1:0]        data_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             addr_ok;
    logic             bypass_hit;

    assign addr_ok    = addr_valid(32'(addr_i), DEPTH, ZERO_REG0 != 0);
    assign bypass_hit = (BYPASS != 0) && wr_en_i && (wr_addr_i == addr_i);

    always_comb begin
        data_d = data_q;
        if (!ready_i) begin
            data_d = '0;
        end else if (rd_en_i) begin
            if (!addr_ok) begin
                data_d = '0;
            end else if (bypass_hit) begin
                data_d = wr_data_i;
            end else begin
                data_d = rf_data_i;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Two-read/one-write operand store with a post-reset sequential clear engine.
//   state    | meaning
//   RF_CLEAR | zeroing one entry per cycle, all accesses ignored, busy high
//   RF_READY | normal reads and writes until the next reset
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDRESSWIDTH = 3,
    parameter int unsigned BYPASS       = 1,
    parameter int unsigned ZERO_REG0    = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    write_enable,
    input  logic [ADDRESSWIDTH-1:0] dest,
    input  logic [WIDTH-1:0]        data_in,
    input  logic                    rd_en_a,
    input  logic [ADDRESSWIDTH-1:0] source_a,
    output logic [WIDTH-1:0]        data_out_a,
    input  logic                    rd_en_b,
    input  logic [ADDRESSWIDTH-1:0] source_b,
    output logic [WIDTH-1:0]        data_out_b,
    output logic                    busy
);

    localparam logic [ADDRESSWIDTH-1:0] LAST_PTR = ADDRESSWIDTH'(DEPTH - 1);

    logic [WIDTH-1:0]        rf_q [DEPTH];
    rf_state_t               state_q;
    logic [ADDRESSWIDTH-1:0] ptr_q;
    logic                    busy_q;
    logic                    ready;
    logic                    wr_accept;
    logic [WIDTH-1:0]        rdata_a;
    logic [WIDTH-1:0]        rdata_b;

    assign ready     = (state_q == RF_READY);
    assign wr_accept = ready && write_enable && addr_valid(32'(dest), DEPTH, ZERO_REG0 != 0);

    // Storage is deliberately left out of the reset branch; the clear engine owns it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= RF_CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            unique case (state_q)
                RF_CLEAR: begin
                    rf_q[ptr_q] <= '0;
                    if (ptr_q == LAST_PTR) begin
                        state_q <= RF_READY;
                        busy_q  <= 1'b0;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                RF_READY: begin
                    if (wr_accept) begin
                        rf_q[dest] <= data_in;
                    end
                end
            endcase
        end
    end

    // Guarded array reads so an out-of-range address never indexes past the array.
    always_comb begin
        rdata_a = '0;
        if (addr_in_range(32'(source_a), DEPTH)) begin
            rdata_a = rf_q[source_a];
        end
    end

    always_comb begin
        rdata_b = '0;
        if (addr_in_range(32'(source_b), DEPTH)) begin
            rdata_b = rf_q[source_b];
        end
    end

    regfile_read_port #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .ADDRESSWIDTH (ADDRESSWIDTH),
        .BYPASS       (BYPASS),
        .ZERO_REG0    (ZERO_REG0)
    ) u_port_a (
        .clock_i   (clock),
        .rst_ni    (reset),
        .ready_i   (ready),
        .rd_en_i   (rd_en_a),
        .addr_i    (source_a),
        .rf_data_i (rdata_a),
        .wr_en_i   (wr_accept),
        .wr_addr_i (dest),
        .wr_data_i (data_in),
        .data_o    (data_out_a)
    );

    regfile_read_port #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .ADDRESSWIDTH (ADDRESSWIDTH),
        .BYPASS       (BYPASS),
        .ZERO_REG0    (ZERO_REG0)
    ) u_port_b (
        .clock_i   (clock),
        .rst_ni    (reset),
        .ready_i   (ready),
        .rd_en_i   (rd_en_b),
        .addr_i    (source_b),
        .rf_data_i (rdata_b),
        .wr_en_i   (wr_accept),
        .wr_addr_i (dest),
        .wr_data_i (data_in),
        .data_o    (data_out_b)
    );

    assign busy = busy_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench driving three builds in lockstep: default, no-bypass, and zero-reg/DEPTH=6.
module tb_regfile_2r1w;

    logic        clock = 1'b0;
    logic        reset;
    logic        write_enable;
    logic [2:0]  dest;
    logic [15:0] data_in;
    logic        rd_en_a;
    logic [2:0]  source_a;
    logic        rd_en_b;
    logic [2:0]  source_b;

    logic [15:0] a_d, b_d, a_n, b_n, a_z, b_z;
    logic        busy_d, busy_n, busy_z;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    regfile_2r1w #(.WIDTH(16), .DEPTH(8), .ADDRESSWIDTH(3), .BYPASS(1), .ZERO_REG0(0)) u_dut (
        .clock(clock), .reset(reset), .write_enable(write_enable), .dest(dest), .data_in(data_in),
        .rd_en_a(rd_en_a), .source_a(source_a), .data_out_a(a_d),
        .rd_en_b(rd_en_b), .source_b(source_b), .data_out_b(b_d), .busy(busy_d));

    regfile_2r1w #(.WIDTH(16), .DEPTH(8), .ADDRESSWIDTH(3), .BYPASS(0), .ZERO_REG0(0)) u_nb (
        .clock(clock), .reset(reset), .write_enable(write_enable), .dest(dest), .data_in(data_in),
        .rd_en_a(rd_en_a), .source_a(source_a), .data_out_a(a_n),
        .rd_en_b(rd_en_b), .source_b(source_b), .data_out_b(b_n), .busy(busy_n));

    regfile_2r1w #(.WIDTH(16), .DEPTH(6), .ADDRESSWIDTH(3), .BYPASS(1), .ZERO_REG0(1)) u_z (
        .clock(clock), .reset(reset), .write_enable(write_enable), .dest(dest), .data_in(data_in),
        .rd_en_a(rd_en_a), .source_a(source_a), .data_out_a(a_z),
        .rd_en_b(rd_en_b), .source_b(source_b), .data_out_b(b_z), .busy(busy_z));

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic idle();
        write_enable = 1'b0;
        rd_en_a      = 1'b0;
        rd_en_b      = 1'b0;
    endtask

    task automatic test_reset();
        int c_d, c_n, c_z;
        idle();
        dest = '0; data_in = '0; source_a = '0; source_b = '0;
        reset = 1'b0;
        tick();
        tick();
        n_cmp++; if (a_d !== 16'h0 || b_d !== 16'h0) begin n_bad++; $display("FAIL reset_out: got a=%h b=%h expected 0000 0000", a_d, b_d); end
        n_cmp++; if (busy_d !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b expected 1", busy_d); end
        reset = 1'b1;
        c_d = 0; c_n = 0; c_z = 0;
        for (int i = 0; i < 20; i++) begin
            c_d += int'(busy_d);
            c_n += int'(busy_n);
            c_z += int'(busy_z);
            tick();
        end
        n_cmp++; if (c_d != 8) begin n_bad++; $display("FAIL busy_len_d8: got %0d expected 8", c_d); end
        n_cmp++; if (c_n != 8) begin n_bad++; $display("FAIL busy_len_nb: got %0d expected 8", c_n); end
        n_cmp++; if (c_z != 6) begin n_bad++; $display("FAIL busy_len_d6: got %0d expected 6", c_z); end
    endtask

    task automatic test_reset_clear();
        int c_d;
        for (int i = 0; i < 8; i++) begin
            write_enable = 1'b1; dest = 3'(i); data_in = 16'hFFFF;
            tick();
        end
        idle();
        rd_en_a = 1'b1; source_a = 3'd4;
        tick();
        rd_en_a = 1'b0;
        n_cmp++; if (a_d !== 16'hFFFF) begin n_bad++; $display("FAIL preload_rd4: got %h expected ffff", a_d); end
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        c_d = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy_d) break;
            c_d++;
            tick();
        end
        n_cmp++; if (c_d != 8) begin n_bad++; $display("FAIL clear_busy_len: got %0d expected 8", c_d); end
        tick();
        for (int i = 0; i < 8; i++) begin
            rd_en_a = 1'b1; source_a = 3'(i);
            rd_en_b = 1'b1; source_b = 3'(i);
            tick();
            n_cmp++; if (a_d !== 16'h0 || b_d !== 16'h0) begin n_bad++; $display("FAIL cleared_entry%0d: got a=%h b=%h expected 0000 0000", i, a_d, b_d); end
        end
        idle();
    endtask

    task automatic test_basic();
        write_enable = 1'b1; dest = 3'd3; data_in = 16'h1234;
        tick();
        dest = 3'd5; data_in = 16'hBEEF;
        tick();
        idle();
        rd_en_a = 1'b1; source_a = 3'd3;
        rd_en_b = 1'b1; source_b = 3'd5;
        tick();
        n_cmp++; if (a_d !== 16'h1234 || b_d !== 16'hBEEF) begin n_bad++; $display("FAIL basic_rd: got a=%h b=%h expected 1234 beef", a_d, b_d); end
        n_cmp++; if (a_n !== 16'h1234 || b_n !== 16'hBEEF) begin n_bad++; $display("FAIL basic_rd_nb: got a=%h b=%h expected 1234 beef", a_n, b_n); end
        rd_en_a = 1'b0; source_a = 3'd0;
        rd_en_b = 1'b0; source_b = 3'd1;
        tick();
        tick();
        n_cmp++; if (a_d !== 16'h1234 || b_d !== 16'hBEEF) begin n_bad++; $display("FAIL basic_hold: got a=%h b=%h expected 1234 beef", a_d, b_d); end
    endtask

    task automatic test_bypass();
        write_enable = 1'b1; dest = 3'd2; data_in = 16'h0001;
        tick();
        data_in = 16'h0A0A;
        rd_en_a = 1'b1; source_a = 3'd2;
        rd_en_b = 1'b1; source_b = 3'd2;
        tick();
        n_cmp++; if (a_d !== 16'h0A0A) begin n_bad++; $display("FAIL bypass_on: got %h expected 0a0a", a_d); end
        n_cmp++; if (a_n !== 16'h0001) begin n_bad++; $display("FAIL bypass_off: got %h expected 0001", a_n); end
        n_cmp++; if (b_d !== a_d || b_n !== a_n) begin n_bad++; $display("FAIL same_addr_ab: got b=%h/%h expected %h/%h", b_d, b_n, a_d, a_n); end
        write_enable = 1'b0;
        tick();
        n_cmp++; if (a_d !== 16'h0A0A || a_n !== 16'h0A0A || a_z !== 16'h0A0A) begin n_bad++; $display("FAIL bypass_after: got %h %h %h expected 0a0a", a_d, a_n, a_z); end
        idle();
    endtask

    task automatic test_zero_oor();
        logic [15:0] exp_z [6];
        exp_z[0] = 16'h0;    exp_z[1] = 16'h0; exp_z[2] = 16'h0A0A;
        exp_z[3] = 16'h1234; exp_z[4] = 16'h0; exp_z[5] = 16'hBEEF;
        write_enable = 1'b1; dest = 3'd0; data_in = 16'h5555;
        tick();
        idle();
        rd_en_a = 1'b1; source_a = 3'd0;
        tick();
        n_cmp++; if (a_z !== 16'h0000) begin n_bad++; $display("FAIL zero_reg: got %h expected 0000", a_z); end
        n_cmp++; if (a_d !== 16'h5555) begin n_bad++; $display("FAIL reg0_normal: got %h expected 5555", a_d); end
        idle();
        write_enable = 1'b1; dest = 3'd7; data_in = 16'h7777;
        tick();
        idle();
        rd_en_b = 1'b1; source_b = 3'd7;
        tick();
        n_cmp++; if (b_z !== 16'h0000) begin n_bad++; $display("FAIL oor_read: got %h expected 0000", b_z); end
        n_cmp++; if (b_d !== 16'h7777) begin n_bad++; $display("FAIL inrange_7: got %h expected 7777", b_d); end
        idle();
        for (int i = 0; i < 6; i++) begin
            rd_en_a = 1'b1; source_a = 3'(i);
            tick();
            n_cmp++; if (a_z !== exp_z[i]) begin n_bad++; $display("FAIL d6_entry%0d: got %h expected %h", i, a_z, exp_z[i]); end
        end
        idle();
    endtask

    task automatic test_midclear();
        int c_d;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        write_enable = 1'b1; dest = 3'd1; data_in = 16'h9999;
        rd_en_a = 1'b1; source_a = 3'd3;
        tick();
        tick();
        tick();
        n_cmp++; if (busy_d !== 1'b1 || a_d !== 16'h0) begin n_bad++; $display("FAIL busy_block: got busy=%b a=%h expected 1 0000", busy_d, a_d); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        c_d = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy_d) break;
            c_d++;
            if (c_d == 4) write_enable = 1'b0;
            tick();
        end
        n_cmp++; if (c_d != 8) begin n_bad++; $display("FAIL midclear_busy_len: got %0d expected 8", c_d); end
        idle();
        rd_en_a = 1'b1; source_a = 3'd1;
        rd_en_b = 1'b1; source_b = 3'd3;
        tick();
        n_cmp++; if (a_d !== 16'h0 || b_d !== 16'h0) begin n_bad++; $display("FAIL busy_write_dropped: got a=%h b=%h expected 0000 0000", a_d, b_d); end
        idle();
    endtask

    initial begin
        test_reset();
        test_reset_clear();
        test_basic();
        test_bypass();
        test_zero_oor();
        test_midclear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
